neuron_accumulator: RTL and testbench

- Downstream stage of the sign-magnitude fixed-point multiplier.
- Accumulates a stream of N-bit sign-magnitude products (a*w) plus a per-neuron bias into a wide two's-complement register.
- Emits one saturated N-bit sign-magnitude neuron output per transaction.
- Sits between the multiplier array and the next layer's activation input buffer.

---
 rtl/neuron_accumulator.sv | 156 +++++++++++++++
 tb/tb_neuron_accumulator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums a bias plus a stream of sign-magnitude products into a saturating two's-complement register.
// Latency: result is valid the cycle after the last accepted beat; a new start is taken in the cycle after the result handshake.
// Backpressure: in_ready_o is high only while accumulating; the result is held stable in DONE until out_ready_i.
// Optional build macro NEURON_ACC_RELU_EN: when defined, negative results are clamped to zero at output conversion.
module neuron_accumulator #(
    parameter int N         = 8,
    parameter int GUARD     = 4,
    parameter int MAX_TERMS = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] bias_i,
    input  logic         in_valid_i,
    input  logic [N-1:0] in_data_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [N-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic         busy_o,
    output logic         overflow_o
);
    localparam int ACC_W = N + GUARD + 1;
    localparam int CNT_W = $clog2(MAX_TERMS) + 1;

    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((1 << (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MAX_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [N-1:0]             out_data_q, out_data_d;
    logic                     overflow_q, overflow_d;

    logic                     beat_acc;
    logic                     last_beat;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [N:0]               conv_res;

    // Sign-magnitude to two's complement; negative zero naturally maps to 0.
    function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [N-1:0] x);
        logic signed [ACC_W-1:0] mag;
        mag = {{(GUARD+2){1'b0}}, x[N-2:0]};
        return x[N-1] ? -mag : mag;
    endfunction

    // Add with clamping at the accumulator rails instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        return sum[ACC_W-1:0];
    endfunction

    // Accumulator to {overflow, sign-magnitude result}; in-range values never produce negative zero.
    function automatic logic [N:0] tc_to_sm(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] mag;
        mag = a[ACC_W-1] ? -a : a;
        if (a > POS_LIM) begin
            return {1'b1, 1'b0, {(N-1){1'b1}}};
        end
`ifdef NEURON_ACC_RELU_EN
        if (a[ACC_W-1]) begin
            return '0;
        end
`else
        if (a < NEG_LIM) begin
            return {1'b1, 1'b1, {(N-1){1'b1}}};
        end
`endif
        return {1'b0, a[ACC_W-1], mag[N-2:0]};
    endfunction

    assign beat_acc  = in_valid_i && (state_q == ACCUM);
    assign last_beat = beat_acc && (in_last_i || (cnt_q == CNT_LAST));
    assign acc_sum   = sat_add(acc_q, sm_to_tc(in_data_i));
    assign conv_res  = tc_to_sm(acc_sum);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)     state_d = ACCUM;
            ACCUM:   if (last_beat)   state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        in_ready_o  = (state_q == ACCUM);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q != IDLE);
        out_data_o  = out_data_q;
        overflow_o  = overflow_q;
    end

    // Datapath next-state: load bias on start, accumulate beats, capture the result on the last beat.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;
        if (state_q == IDLE && start_i) begin
            acc_d      = sm_to_tc(bias_i);
            cnt_d      = '0;
            overflow_d = 1'b0;
        end else if (beat_acc) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_beat) begin
                overflow_d = conv_res[N];
                out_data_d = conv_res[N-1:0];
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: directed cases plus randomized transactions.
// Expected results come from integer arithmetic on the signed values of the operands.
// Inputs are driven and outputs sampled on the falling edge.
module tb_neuron_accumulator;
    localparam int N  = 8;
    localparam int MT = 16;
    localparam int ACC_HI = 4095;
    localparam int ACC_LO = -4096;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_last, out_ready;
    logic [7:0] bias, in_data;
    logic       in_ready, out_valid, busy, overflow;
    logic [7:0] out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_accumulator #(.N(N), .GUARD(4), .MAX_TERMS(MT)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bias_i(bias),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last),
        .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
        .out_ready_i(out_ready), .busy_o(busy), .overflow_o(overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sm_val(input logic [7:0] x);
        return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
    endfunction

    function automatic int clamp(input int v);
        if (v > ACC_HI) return ACC_HI;
        if (v < ACC_LO) return ACC_LO;
        return v;
    endfunction

    // Expected {overflow, out_data} for a final accumulator value.
    function automatic logic [8:0] expect_out(input int acc);
        logic [7:0] m;
        if (acc > 127) return {1'b1, 8'h7F};
`ifdef NEURON_ACC_RELU_EN
        if (acc < 0) return 9'h000;
`else
        if (acc < -127) return {1'b1, 8'hFF};
        if (acc < 0) begin
            m = 8'(-acc);
            return {1'b0, 1'b1, m[6:0]};
        end
`endif
        m = 8'(acc);
        return {1'b0, m};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Runs one full transaction and checks latency, holding and handshake behaviour.
    task automatic run_txn(input string tag, input logic [7:0] b, input byte_q_t beats,
                           input bit use_last, input int gap_max, input int stall);
        int acc;
        int n;
        logic [8:0] exp;
        acc = sm_val(b);
        foreach (beats[i]) acc = clamp(acc + sm_val(beats[i]));
        exp = expect_out(acc);

        // in_valid in IDLE must not be accepted
        in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b1;
        check({tag, "_idle_rdy"}, in_ready, 0);
        tick();
        in_valid = 1'b0; in_last = 1'b0;

        start = 1'b1; bias = b;
        tick();
        start = 1'b0; bias = 8'($urandom);
        check({tag, "_busy"}, busy, 1);

        foreach (beats[i]) begin
            for (int g = 0; g < int'($urandom_range(0, gap_max)); g++) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1; in_data = beats[i];
            in_last = use_last && (i == beats.size() - 1);
            n = 0;
            while (!in_ready && n < 20) begin tick(); n++; end
            if (n != 0) check({tag, "_rdy_timeout"}, in_ready, 1);
            tick();
            in_valid = 1'b0; in_last = 1'b0;
        end

        check({tag, "_lat"}, out_valid, 1);
        check({tag, "_rdy_done"}, in_ready, 0);
        check({tag, "_data"}, out_data, exp[7:0]);
        check({tag, "_ovf"}, overflow, exp[8]);

        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0; start = 1'b1;
            tick();
            check({tag, "_hold_vld"}, out_valid, 1);
            check({tag, "_hold_data"}, out_data, exp[7:0]);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_clr_vld"}, out_valid, 0);
        check({tag, "_clr_busy"}, busy, 0);
        check({tag, "_keep_data"}, out_data, exp[7:0]);
    endtask

    initial begin
        byte_q_t q;
        int nb;
        bit ul;

        rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_rdy", in_ready, 0);
        check("rst_vld", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        q = '{8'h40, 8'h20};         run_txn("t1", 8'h00, q, 1, 0, 0);
        q = '{8'h40, 8'hA0};         run_txn("t2a", 8'h10, q, 1, 0, 0);
        q = '{8'h40, 8'hC0};         run_txn("t2b", 8'h00, q, 1, 0, 0);
        q = '{8'h80, 8'h80};         run_txn("t2c", 8'h00, q, 1, 0, 0);
        q = '{8'h7F, 8'h7F};         run_txn("t3p", 8'h7F, q, 1, 0, 0);
        q = '{8'hFF, 8'hFF};         run_txn("t3n", 8'hFF, q, 1, 0, 0);
        q = {};
        for (int i = 0; i < MT; i++) q.push_back(8'h01);
        run_txn("t4", 8'h00, q, 0, 0, 0);
        q = '{8'h11};                run_txn("t5", 8'h02, q, 1, 0, 3);

        // reset in the middle of a transaction
        start = 1'b1; bias = 8'h33;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h21;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_rdy", in_ready, 0);
        check("t6_vld", out_valid, 0);
        q = '{8'h05};                run_txn("t6", 8'h00, q, 1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            q = {};
            nb = $urandom_range(1, MT);
            ul = (nb < MT) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom_range(0, 1) ? 8'hFF : 8'h7F));
                else q.push_back(8'($urandom));
            end
            run_txn("rnd", 8'($urandom), q, ul, 2, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
